// File: rtl/packet_router.sv
// packet_router
// Receive-side router stage. Accepts 13-bit flits over a valid/ready
// handshake, buffers them in a first-word-fall-through FIFO and steers every
// flit of a packet to one of four destination ports. The port is taken from
// the head flit's destination field and stays locked until the flit carrying
// end_of_packet has been accepted downstream.
//
// Flit layout: [12:11] destination, [10:9] type, [8:1] payload, [0] eop.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. A valid, once raised, holds with stable data until it is
// accepted; ready may depend on nothing but registered state (and rst_n).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   src_valid/src_ready upstream handshake; packet carries the flit
//   dst_valid[3:0]      one-hot per-port valid; dst_ready[3:0] per-port ready
//   dst_type/payload/eop fields of the FIFO head flit, shared by all ports
//   pkt_count           completed-packet count (only with PACKET_ROUTER_CNT_EN)
//   dbg_state           current FSM state (0 = IDLE, 1 = FWD)
//
// Build option: define PACKET_ROUTER_CNT_EN to add the saturating pkt_count
// output and its counter.

module packet_router #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [12:0] packet,
  output logic [3:0]  dst_valid,
  input  logic [3:0]  dst_ready,
  output logic [1:0]  dst_type,
  output logic [7:0]  dst_payload,
  output logic        dst_eop,
`ifdef PACKET_ROUTER_CNT_EN
  output logic [15:0] pkt_count,
`endif
  output logic        dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FWD  = 1'b1;

  logic [12:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [0:0]    state_q, state_d;
  logic [1:0]    lock_port_q, lock_port_d;

  logic        empty;
  logic        push;
  logic        pop;
  logic [12:0] head;

  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a full FIFO; rst_n is folded in so ready is low during reset.
  assign src_ready = (count_q < CW'(DEPTH)) && rst_n;
  assign push      = src_valid && src_ready;
  assign pop       = (state_q == ST_FWD) && !empty && dst_ready[lock_port_q];

  assign dst_type    = head[10:9];
  assign dst_payload = head[8:1];
  assign dst_eop     = head[0];
  assign dbg_state   = state_q;

  always_comb begin
    dst_valid = '0;
    if (state_q == ST_FWD && !empty) dst_valid[lock_port_q] = 1'b1;
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Port-lock FSM: the port is latched from the head flit in IDLE and held
  // until the eop flit is popped, so body-flit destinations are ignored.
  always_comb begin
    state_d     = state_q;
    lock_port_d = lock_port_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          lock_port_d = head[12:11];
          state_d     = ST_FWD;
        end
      end
      ST_FWD: begin
        if (pop && head[0]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage is cleared on reset so the shared head fields read 0 as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= packet;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      lock_port_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      lock_port_q <= lock_port_d;
    end
  end

`ifdef PACKET_ROUTER_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop && head[0] && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pkt_cnt_q <= '0;
    else        pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_packet_router.sv
// Testbench for packet_router: directed flit sequences, a scoreboard queue of
// expected deliveries filled at issue time and a monitor that checks every
// accepted output flit against it.

module tb_packet_router;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        src_valid;
  logic        src_ready;
  logic [12:0] packet;
  logic [3:0]  dst_valid;
  logic [3:0]  dst_ready;
  logic [1:0]  dst_type;
  logic [7:0]  dst_payload;
  logic        dst_eop;
  logic        dbg_state;
`ifdef PACKET_ROUTER_CNT_EN
  logic [15:0] pkt_count;
`endif

  packet_router #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .packet      (packet),
    .dst_valid   (dst_valid),
    .dst_ready   (dst_ready),
    .dst_type    (dst_type),
    .dst_payload (dst_payload),
    .dst_eop     (dst_eop),
`ifdef PACKET_ROUTER_CNT_EN
    .pkt_count   (pkt_count),
`endif
    .dbg_state   (dbg_state)
  );

  int n_tests   = 0;
  int n_fail    = 0;
  int stall_cnt = 0;
  int cyc       = 0;

  // expected entry: {one-hot port, type, payload, eop}
  logic [14:0] exp_q[$];
  logic [14:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge with
  // src_valid still high so consecutive calls stream one flit per cycle.
  task automatic send(input logic [1:0] dest, input logic [1:0] typ,
                      input logic [7:0] pay, input logic eop, input logic [1:0] port);
    logic       acc;
    logic [3:0] oh;
    int         guard;
    guard = 0;
    oh = 4'b0001 << port;
    exp_q.push_back({oh, typ, pay, eop});
    src_valid = 1'b1;
    packet    = {dest, typ, pay, eop};
    do begin
      @(negedge clk);
      acc = src_ready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || dbg_state != 1'b0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && dbg_state == 1'b0)}, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if (!$onehot0(dst_valid)) begin
        n_fail++;
        $display("FAIL onehot: got %b expected at most one bit", dst_valid);
      end
      if (|(dst_valid & dst_ready)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got %h expected no flit",
                   {dst_valid, dst_type, dst_payload, dst_eop});
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_flit", {17'd0, dst_valid, dst_type, dst_payload, dst_eop}, {17'd0, mon_e});
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int start_cyc;

  initial begin
    rst_n     = 1'b0;
    src_valid = 1'b0;
    packet    = '0;
    dst_ready = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_src_ready", src_ready, 0);
    check("rst_dst_valid", dst_valid, 0);
    check("rst_dst_type", dst_type, 0);
    check("rst_dst_payload", dst_payload, 0);
    check("rst_dst_eop", dst_eop, 0);
    check("rst_state", dbg_state, 0);
`ifdef PACKET_ROUTER_CNT_EN
    check("rst_pkt_count", pkt_count, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", src_ready, 1);
    @(posedge clk); #1;

    // single-flit packet: head latency and return to IDLE
    dst_ready = 4'hF;
    send(2'd2, 2'd1, 8'hA5, 1'b1, 2'd2);
    src_valid = 1'b0;
    @(negedge clk);
    check("t1_valid_n1", dst_valid, 4'b0000);
    @(negedge clk);
    check("t1_valid_n2", dst_valid, 4'b0100);
    check("t1_payload", dst_payload, 8'hA5);
    check("t1_type", dst_type, 2'd1);
    check("t1_eop", dst_eop, 1'b1);
    @(negedge clk);
    check("t1_idle", dbg_state, 0);
    check("t1_valid_after", dst_valid, 4'b0000);
`ifdef PACKET_ROUTER_CNT_EN
    check("t1_pkt_count", pkt_count, 1);
`endif
    @(posedge clk); #1;

    // port lock: body flits carry another destination
    send(2'd1, 2'd0, 8'h11, 1'b0, 2'd1);
    send(2'd3, 2'd2, 8'h22, 1'b0, 2'd1);
    send(2'd3, 2'd3, 8'h33, 1'b1, 2'd1);
    src_valid = 1'b0;
    wait_drain("t2_drain");
    @(posedge clk); #1;

    // backpressure / full
    dst_ready = 4'h0;
    for (int i = 0; i < 4; i++)
      send(2'd0, 2'd2, 8'h40 + 8'(i), (i == 3), 2'd0);
    src_valid = 1'b1;
    packet    = {2'd0, 2'd2, 8'h44, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_full_ready", src_ready, 0);
      check("t3_hold_valid", dst_valid, 4'b0001);
      check("t3_hold_payload", dst_payload, 8'h40);
    end
    @(posedge clk); #1;
    src_valid = 1'b0;
    dst_ready = 4'hF;
    @(negedge clk);
    check("t3_ready_before_pop", src_ready, 0);
    @(negedge clk);
    check("t3_ready_after_pop", src_ready, 1);
    wait_drain("t3_drain");
    @(posedge clk); #1;

    // simultaneous push and pop: streaming without stalls
    stall_cnt = 0;
    start_cyc = cyc;
    send(2'd2, 2'd0, 8'h60, 1'b0, 2'd2);
    for (int i = 1; i < 6; i++)
      send(2'(i), 2'd1, 8'h60 + 8'(i), (i == 5), 2'd2);
    src_valid = 1'b0;
    wait_drain("t4_drain");
    check("t4_stalls", stall_cnt, 0);
    check("t4_throughput", {31'd0, (cyc - start_cyc) <= 10}, 32'd1);
    @(posedge clk); #1;

    // reset mid-packet
    dst_ready = 4'h0;
    send(2'd3, 2'd1, 8'h70, 1'b0, 2'd3);
    send(2'd0, 2'd1, 8'h71, 1'b0, 2'd3);
    src_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_valid", dst_valid, 4'b1000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", dst_valid, 0);
    check("t5_rst_payload", dst_payload, 0);
    check("t5_rst_type", dst_type, 0);
    check("t5_rst_eop", dst_eop, 0);
    check("t5_rst_ready", src_ready, 0);
    check("t5_rst_state", dbg_state, 0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dst_ready = 4'hF;
    send(2'd0, 2'd3, 8'h7F, 1'b1, 2'd0);
    src_valid = 1'b0;
    wait_drain("t5_drain");
`ifdef PACKET_ROUTER_CNT_EN
    check("t5_pkt_count", pkt_count, 1);
    @(posedge clk); #1;

    // counter saturation
    force dut.pkt_cnt_q = 16'hFFFE;
    #1;
    release dut.pkt_cnt_q;
    check("t6_forced", pkt_count, 16'hFFFE);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      send(2'(i), 2'd0, 8'h90 + 8'(i), 1'b1, 2'(i));
      src_valid = 1'b0;
      wait_drain("t6_drain");
      @(posedge clk); #1;
    end
    check("t6_saturated", pkt_count, 16'hFFFF);
`endif

    repeat (2) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
